// File: rtl/mach_ram_pkg.sv
// rtl/mach_ram_pkg.sv - shared state type and half-select helpers for the CPU RAM bridge
package mach_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    // A halfword transaction is needed when either byte lane of the pair is enabled (active low).
    function automatic logic half_needed(input logic [1:0] ben_pair);
        return ~&ben_pair;
    endfunction

endpackage

// File: rtl/mach_ram_bridge.sv
// rtl/mach_ram_bridge.sv - splits one 32-bit CPU RAM cycle into up to two 16-bit req/ack transactions
module mach_ram_bridge
    import mach_ram_pkg::*;
#(
    parameter int CPU_AW = 21,
    parameter int MEM_AW = 20
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              CE,
    input  logic              BCYSTn,
    input  logic [CPU_AW-1:0] RAM_A,
    input  logic [31:0]       RAM_DI,
    output logic [31:0]       RAM_DO,
    input  logic              RAM_CEn,
    input  logic              RAM_WEn,
    input  logic [3:0]        RAM_BEn,
    output logic              RAM_READYn,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [MEM_AW-1:0] MEM_A,
    output logic [1:0]        MEM_BE,
    output logic [15:0]       MEM_D,
    input  logic [15:0]       MEM_Q,
    input  logic              MEM_ACK
);

    localparam int WORD_W = CPU_AW - 2;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [31:0]         di_q, di_d;
    logic [3:0]          ben_q, ben_d;
    logic                wen_q, wen_d;
    logic                mem_req_d, mem_we_d, ready_n_d;
    logic [MEM_AW-1:0]   mem_a_d;
    logic [1:0]          mem_be_d;
    logic [15:0]         mem_d_d;
    logic [31:0]         ram_do_d;
    logic                start;

    // Byte offset within the word is implied by the byte enables.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^RAM_A[1:0];

    assign start = CE & ~BCYSTn & ~RAM_CEn;

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        di_d      = di_q;
        ben_d     = ben_q;
        wen_d     = wen_q;
        mem_req_d = MEM_REQ;
        mem_we_d  = MEM_WE;
        mem_a_d   = MEM_A;
        mem_be_d  = MEM_BE;
        mem_d_d   = MEM_D;
        ram_do_d  = RAM_DO;
        ready_n_d = RAM_READYn;

        case (state_q)
            IDLE: begin
                if (start) begin
                    word_d   = RAM_A[CPU_AW-1:2];
                    di_d     = RAM_DI;
                    ben_d    = RAM_BEn;
                    wen_d    = RAM_WEn;
                    mem_we_d = ~RAM_WEn;
                    ram_do_d = '0;
                    if (half_needed(RAM_BEn[1:0])) begin
                        state_d   = LO;
                        mem_req_d = 1'b1;
                        mem_a_d   = {RAM_A[CPU_AW-1:2], HALF_LO};
                        mem_be_d  = ~RAM_BEn[1:0];
                        mem_d_d   = RAM_DI[15:0];
                    end else if (half_needed(RAM_BEn[3:2])) begin
                        state_d   = HI;
                        mem_req_d = 1'b1;
                        mem_a_d   = {RAM_A[CPU_AW-1:2], HALF_HI};
                        mem_be_d  = ~RAM_BEn[3:2];
                        mem_d_d   = RAM_DI[31:16];
                    end else begin
                        state_d   = DONE;
                        ready_n_d = 1'b0;
                    end
                end
            end
            LO: begin
                if (MEM_ACK) begin
                    if (wen_q) ram_do_d[15:0] = MEM_Q;
                    if (half_needed(ben_q[3:2])) begin
                        // REQ stays high; address/enables switch only on this ACK edge.
                        state_d  = HI;
                        mem_a_d  = {word_q, HALF_HI};
                        mem_be_d = ~ben_q[3:2];
                        mem_d_d  = di_q[31:16];
                    end else begin
                        state_d   = DONE;
                        mem_req_d = 1'b0;
                        ready_n_d = 1'b0;
                    end
                end
            end
            HI: begin
                if (MEM_ACK) begin
                    if (wen_q) ram_do_d[31:16] = MEM_Q;
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    ready_n_d = 1'b0;
                end
            end
            DONE: begin
                if (CE) begin
                    state_d   = IDLE;
                    ready_n_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q    <= IDLE;
            word_q     <= '0;
            di_q       <= '0;
            ben_q      <= 4'hF;
            wen_q      <= 1'b1;
            MEM_REQ    <= 1'b0;
            MEM_WE     <= 1'b0;
            MEM_A      <= '0;
            MEM_BE     <= '0;
            MEM_D      <= '0;
            RAM_DO     <= '0;
            RAM_READYn <= 1'b1;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            di_q       <= di_d;
            ben_q      <= ben_d;
            wen_q      <= wen_d;
            MEM_REQ    <= mem_req_d;
            MEM_WE     <= mem_we_d;
            MEM_A      <= mem_a_d;
            MEM_BE     <= mem_be_d;
            MEM_D      <= mem_d_d;
            RAM_DO     <= ram_do_d;
            RAM_READYn <= ready_n_d;
        end
    end

endmodule

// File: doc/mach_ram_bridge.md
# mach_ram_bridge

Adapter between the machine's 32-bit CPU RAM port and a 16-bit request/acknowledge memory back end (SDRAM controller or BRAM wrapper). Accepts one CPU RAM bus cycle at a time and splits it into zero, one or two halfword transactions according to the byte enables. Assembles read data into 32 bits and returns RAM_READYn to the CPU side, aligned to the CPU clock enable.

## Interface
Parameters:
- CPU_AW, 21, CPU-side byte address width.
- MEM_AW, 20, back-end halfword address width; must equal CPU_AW-1.

Ports:
- CLK in 1: system clock.
- RES in 1: reset, synchronous and active-high.
- CE in 1: CPU clock enable; CPU samples RAM_READYn and drives new cycles only on CE.
- BCYSTn in 1: CPU bus-cycle start strobe, active low.
- RAM_A in CPU_AW: byte address; bits [1:0] ignored.
- RAM_DI in 32: write data from CPU.
- RAM_DO out 32: read data to CPU.
- RAM_CEn in 1: RAM select, active low.
- RAM_WEn in 1: 1 = read, 0 = write.
- RAM_BEn in 4: byte enables, active low; bit n selects byte lane n.
- RAM_READYn out 1: cycle complete, active low.
- MEM_REQ out 1: transaction request, level.
- MEM_WE out 1: 1 = write.
- MEM_A out MEM_AW: halfword address.
- MEM_BE out 2: byte enables, active high.
- MEM_D out 16: write data.
- MEM_Q in 16: read data, valid on MEM_ACK.
- MEM_ACK in 1: one-cycle pulse completing the current transaction.

## Operation
- States: IDLE, LO, HI, DONE.
- IDLE: on CE & ~BCYSTn & ~RAM_CEn, latch RAM_A[CPU_AW-1:2], RAM_DI, RAM_BEn, RAM_WEn.
  - need_lo = ~BEn[0] | ~BEn[1]; need_hi = ~BEn[2] | ~BEn[3].
  - Next state: LO if need_lo, else HI if need_hi, else DONE.
  - Clear RAM_DO to 0 at start.
- LO: MEM_A = {word, 1'b0}; MEM_BE = ~BEn[1:0]; MEM_D = DI[15:0].
  - On MEM_ACK: read latches MEM_Q into RAM_DO[15:0]; go to HI if need_hi, else DONE.
- HI: MEM_A = {word, 1'b1}; MEM_BE = ~BEn[3:2]; MEM_D = DI[31:16].
  - On MEM_ACK: read latches MEM_Q into RAM_DO[31:16]; go to DONE.
- DONE: RAM_READYn = 0. On CE, go to IDLE with RAM_READYn = 1 the following cycle.
- Unfetched read halves return 16'h0000. Write cycles leave RAM_DO unchanged from its cleared value.
- MEM_REQ = 1 exactly while in LO or HI. It stays continuously high across LO→HI; each MEM_ACK completes one transaction.
- MEM_WE = ~latched WEn, held constant for the whole cycle.
- Back end must not see MEM_A or MEM_BE change while MEM_REQ = 1 except on the ACK edge.

## Timing
- All outputs registered.
- Reset values: MEM_REQ 0, MEM_WE 0, MEM_A 0, MEM_BE 0, MEM_D 0, RAM_DO 0, RAM_READYn 1, state IDLE.
- Latency counts CLK cycles from the start cycle to the first cycle with RAM_READYn = 0, assuming MEM_ACK in the first REQ cycle:
  - 32-bit access: 3 cycles.
  - 16-bit access: 2 cycles.
  - RAM_BEn = 4'hF: 1 cycle, with no MEM_REQ.
- MEM_ACK is ignored when MEM_REQ = 0 (including IDLE and DONE).
- RAM_CEn or BCYSTn changes after the start cycle are ignored; the latched cycle always completes.
- A new start is recognised only in IDLE. A start strobe during LO, HI or DONE is a protocol error and is dropped.
- CE in the same cycle that DONE is entered does not count. RAM_READYn must be low for at least one full CE cycle.
- RES mid-transaction returns to IDLE next cycle with MEM_REQ 0. A late MEM_ACK is ignored.

## Structure
- Package mach_ram_pkg holds:
  - state enum (IDLE, LO, HI, DONE);
  - localparam HALF_LO = 1'b0 and HALF_HI = 1'b1;
  - function half_needed(BEn pair).
- Single module, no sub-modules. The datapath is the latch registers plus the half select mux.

## Test plan
- 32-bit read at byte address 0x000104, BEn 4'h0, ACK immediate:
  - MEM_A 0x00082 then 0x00083; MEM_Q 0x5678 then 0x1234.
  - RAM_DO 0x12345678; RAM_READYn low on cycle 3.
- Byte write to 0x000007, BEn 4'h7, DI 0xAB000000:
  - One transaction only: MEM_A 0x00003, MEM_BE 2'b10, MEM_D 0xAB00, MEM_WE 1.
- Halfword read with BEn 4'hC and MEM_ACK delayed 5 cycles:
  - MEM_REQ high for 5 cycles; RAM_DO[31:16] = 0.
  - RAM_READYn held until the next CE.
- BEn 4'hF:
  - No MEM_REQ; RAM_READYn low one cycle after start.
  - Stays low until CE (CE every 4th CLK), then high.
- RES asserted during HI with ACK arriving 1 cycle after RES:
  - State IDLE, MEM_REQ 0, RAM_READYn 1.
  - Stray ACK ignored; the next start proceeds normally.
